data_bus_responder: RTL
=======================

DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit storage words (power of two, at least 4).
REQ-002 SHALL have parameter TIMER_BASE, default 32'hFFFF_0000, meaning the base address of the timer window (used only with MTIMER_EN).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 i_wb_stb  in  1  access strobe, valid for one cycle per access.
REQ-006 i_wb_we  in  1  1 = store, 0 = load; qualified by i_wb_stb.
REQ-007 i_wb_sel  in  3  data type: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are treated as W.
REQ-008 i_wb_addr  in  32  byte address.
REQ-009 i_wb_data  in  32  store data, zero-extended in the low bits; valid the cycle after the store strobe.
REQ-010 o_wb_data  out  32  load data; combinational, valid in the same cycle as the load strobe.
REQ-011 o_misaligned  out  1  one-cycle registered pulse flagging a misaligned access.
REQ-012 o_timer_irq  out  1  timer interrupt level (MTIMER_EN only; otherwise tied 0).

Function
REQ-013 Decode: word index = i_wb_addr[log2(DEPTH_WORDS)+1:2], lane = i_wb_addr[1:0]; addresses at or above DEPTH_WORDS*4 (outside the timer window) are out of range.
REQ-014 Store capture: on stb&we, latch word index, lane, size and valid into a pending-write register; no array write that cycle.
REQ-015 Store commit: in the cycle after capture, shift i_wb_data[7:0] (B) or i_wb_data[15:0] (H) left by lane*8 into byte lanes, then write only the enabled bytes (W writes all 4); the write lands on that edge.
REQ-016 Back-to-back stores: commit of store N and capture of store N+1 occur on the same edge; sustained throughput is one store per cycle.
REQ-017 Load: o_wb_data = selected bytes, shifted down by lane*8 and sign-extended (B, H) or zero-extended (BU, HU, W); zero-latency combinational path.
REQ-018 Read-after-write: a load to the word held in the valid pending register returns array bytes merged with the pending byte lanes taken from the current i_wb_data (commit-cycle forwarding).
REQ-019 Misalignment: H/HU with lane[0]=1, or W with lane!=0, is dropped (store not captured; load returns 0) and pulses o_misaligned on the next cycle.
REQ-020 Out of range: a load returns 0; a store is dropped; o_misaligned is not asserted.
REQ-021 o_wb_data SHALL be 0 when i_wb_stb=0 or i_wb_we=1.
REQ-022 Storage holds its contents without a write; array contents are undefined after power-up except in simulation, where they are zero.

Reset
REQ-023 rst clears pending valid (an in-flight store is discarded), clears o_misaligned to 0, and sets o_timer_irq to 0.
REQ-024 rst does not clear the storage array.
REQ-025 A strobe arriving in the first edge after rst deasserts SHALL be serviced normally.

Configuration
REQ-026 Macro MTIMER_EN defined: word registers at TIMER_BASE+0/+4 = mtime lo/hi and +8/+C = mtimecmp lo/hi; W access only (B/H accesses are misaligned).
REQ-027 With MTIMER_EN: mtime increments by 1 every cycle and wraps at 2^64; a store to mtime overrides the increment on its commit edge; reset sets mtime=0 and mtimecmp=64'hFFFF_FFFF_FFFF_FFFF.
REQ-028 With MTIMER_EN: o_timer_irq is registered as (mtime >= mtimecmp), unsigned 64-bit.
REQ-029 Without MTIMER_EN: the timer window is out-of-range memory; o_timer_irq is constant 0; no timer registers exist.

Verification
REQ-030 Store W 0x11223344 @0x10, then load W @0x10 two cycles later -> 0x11223344.
REQ-031 Store B 0x80 @0x21, next cycle load B @0x21 (forwarded) -> 0xFFFFFF80; load BU -> 0x00000080; bytes 0x20/0x22/0x23 unchanged.
REQ-032 Back-to-back stores H 0xBEEF @0x40 and H 0xCAFE @0x42, then load W @0x40 -> 0xCAFEBEEF.
REQ-033 Store W @0x13 -> no write, o_misaligned=1 for exactly one cycle; load H @0x01 -> 0, o_misaligned pulse.
REQ-034 Store W @0x50 with rst asserted in the commit cycle -> word 0x50 keeps its old value; pending valid=0.
REQ-035 MTIMER_EN: after reset, write mtimecmp lo=20, hi=0 -> o_timer_irq rises once mtime reaches 20; load mtime hi -> 0.

Source files
------------

// File: rtl/data_bus_responder.sv
// -----------------------------------------------------------------------------
// data_bus_responder
//
// Single-cycle data-bus slave backed by a DEPTH_WORDS x 32-bit byte-writable
// store. Loads are answered combinationally in the strobe cycle. Stores are
// captured into a pending-write register and committed on the following edge,
// when their data arrives on i_wb_data. A load to the word being committed
// sees the new bytes straight from the bus.
//
// Optional feature: define MTIMER_EN to add a 64-bit mtime/mtimecmp timer at
// TIMER_BASE (+0 mtime lo, +4 mtime hi, +8 mtimecmp lo, +C mtimecmp hi).
// Without it the timer window is plain out-of-range space and o_timer_irq is 0.
//
// Ports
//   clk           single clock, rising edge
//   rst           asynchronous, active-high reset
//   i_wb_stb      access strobe, one cycle per access
//   i_wb_we       1 = store, 0 = load
//   i_wb_sel      000 B, 001 H, 010 W, 100 BU, 101 HU, others W
//   i_wb_addr     byte address
//   i_wb_data     store data, valid the cycle after the store strobe
//   o_wb_data     load data, same cycle as the load strobe
//   o_misaligned  one-cycle pulse after a misaligned access
//   o_timer_irq   registered (mtime >= mtimecmp), MTIMER_EN only
// -----------------------------------------------------------------------------
module data_bus_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] TIMER_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [2:0]  i_wb_sel,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic [31:0] o_wb_data,
  output logic        o_misaligned,
  output logic        o_timer_irq
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // ---------------------------------------------------------------- decode
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [1:0]    size;
  logic          timer_hit;
  logic          in_mem;
  logic          mis_mem;
  logic          in_tmr;
  logic          mis_tmr;

  always_comb begin
    lane      = i_wb_addr[1:0];
    idx       = i_wb_addr[AW+1:2];
    timer_hit = (i_wb_addr[31:4] == TIMER_BASE[31:4]);
    // The timer window is never storage, even if it were placed below the top.
    in_mem    = (i_wb_addr[31:AW+2] == '0) && !timer_hit;
    case (i_wb_sel[1:0])
      2'b00:   size = SZ_B;
      2'b01:   size = SZ_H;
      default: size = SZ_W;
    endcase
    mis_mem = ((size == SZ_H) && lane[0]) || ((size == SZ_W) && (lane != 2'b00));
  end

  // ------------------------------------------------------- pending write
  logic          pend_valid_q, pend_valid_d;
  logic [AW-1:0] pend_idx_q,   pend_idx_d;
  logic [1:0]    pend_lane_q,  pend_lane_d;
  logic [1:0]    pend_size_q,  pend_size_d;
  logic          misaligned_q, misaligned_d;
  logic          cap_mem;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    cap_mem      = i_wb_stb && i_wb_we && in_mem && !mis_mem;
    pend_valid_d = cap_mem;
    pend_idx_d   = cap_mem ? idx  : pend_idx_q;
    pend_lane_d  = cap_mem ? lane : pend_lane_q;
    pend_size_d  = cap_mem ? size : pend_size_q;
    // Out-of-range accesses never flag misalignment.
    misaligned_d = i_wb_stb && ((in_mem && mis_mem) || (in_tmr && mis_tmr));
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      pend_valid_q <= 1'b0;
      pend_idx_q   <= '0;
      pend_lane_q  <= 2'b00;
      pend_size_q  <= SZ_W;
      misaligned_q <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_idx_q   <= pend_idx_d;
      pend_lane_q  <= pend_lane_d;
      pend_size_q  <= pend_size_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign o_misaligned = misaligned_q;

  // ------------------------------------------------------- commit lanes
  logic [3:0]  wbe;
  logic [31:0] wword;
  logic        commit;

  always_comb begin
    case (pend_size_q)
      SZ_B: begin
        wbe   = 4'b0001 << pend_lane_q;
        wword = {24'd0, i_wb_data[7:0]} << {pend_lane_q, 3'b000};
      end
      SZ_H: begin
        wbe   = 4'b0011 << pend_lane_q;
        wword = {16'd0, i_wb_data[15:0]} << {pend_lane_q, 3'b000};
      end
      default: begin
        wbe   = 4'b1111;
        wword = i_wb_data;
      end
    endcase
    // A reset landing in the commit cycle discards the in-flight store.
    commit = pend_valid_q && !rst;
  end

  // ------------------------------------------------------------ storage
  logic [31:0] mem_q [DEPTH_WORDS];

  // NOTE: the array has no reset on purpose; it is plain RAM and its contents
  // survive rst.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe[b]) mem_q[pend_idx_q][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  // --------------------------------------------------------------- load
  logic [31:0] rd_word;
  logic [31:0] rd_shift;
  logic [31:0] ld_ext;

  always_comb begin
    rd_word = mem_q[idx];
    // Commit-cycle forwarding: bytes about to land come from the bus.
    if (pend_valid_q && (pend_idx_q == idx)) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe[b]) rd_word[8*b +: 8] = wword[8*b +: 8];
      end
    end
    rd_shift = rd_word >> {lane, 3'b000};
    case (size)
      SZ_B:    ld_ext = i_wb_sel[2] ? {24'd0, rd_shift[7:0]}
                                    : {{24{rd_shift[7]}}, rd_shift[7:0]};
      SZ_H:    ld_ext = i_wb_sel[2] ? {16'd0, rd_shift[15:0]}
                                    : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: ld_ext = rd_shift;
    endcase
  end

  // -------------------------------------------------------------- timer
  logic [31:0] tmr_rdata;

`ifdef MTIMER_EN
  logic [63:0] mtime_q,    mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        irq_q,      irq_d;
  logic        tpend_valid_q, tpend_valid_d;
  logic [1:0]  tpend_reg_q,   tpend_reg_d;
  logic        cap_tmr;

  always_comb begin
    in_tmr        = timer_hit;
    mis_tmr       = (size != SZ_W) || (lane != 2'b00);
    cap_tmr       = i_wb_stb && i_wb_we && in_tmr && !mis_tmr;
    tpend_valid_d = cap_tmr;
    tpend_reg_d   = cap_tmr ? i_wb_addr[3:2] : tpend_reg_q;
    mtime_d       = mtime_q + 64'd1;
    mtimecmp_d    = mtimecmp_q;
    // A committed store to mtime replaces that cycle's increment.
    if (tpend_valid_q && !rst) begin
      case (tpend_reg_q)
        2'd0:    mtime_d    = {mtime_q[63:32], i_wb_data};
        2'd1:    mtime_d    = {i_wb_data, mtime_q[31:0]};
        2'd2:    mtimecmp_d = {mtimecmp_q[63:32], i_wb_data};
        default: mtimecmp_d = {i_wb_data, mtimecmp_q[31:0]};
      endcase
    end
    irq_d = (mtime_q >= mtimecmp_q);
    case (i_wb_addr[3:2])
      2'd0:    tmr_rdata = mtime_q[31:0];
      2'd1:    tmr_rdata = mtime_q[63:32];
      2'd2:    tmr_rdata = mtimecmp_q[31:0];
      default: tmr_rdata = mtimecmp_q[63:32];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q       <= 64'd0;
      mtimecmp_q    <= 64'hFFFF_FFFF_FFFF_FFFF;
      irq_q         <= 1'b0;
      tpend_valid_q <= 1'b0;
      tpend_reg_q   <= 2'd0;
    end else begin
      mtime_q       <= mtime_d;
      mtimecmp_q    <= mtimecmp_d;
      irq_q         <= irq_d;
      tpend_valid_q <= tpend_valid_d;
      tpend_reg_q   <= tpend_reg_d;
    end
  end

  assign o_timer_irq = irq_q;
`else
  always_comb begin
    in_tmr    = 1'b0;
    mis_tmr   = 1'b0;
    tmr_rdata = '0;
  end

  assign o_timer_irq = 1'b0;
`endif

  // --------------------------------------------------------- read mux
  always_comb begin
    o_wb_data = '0;
    if (i_wb_stb && !i_wb_we) begin
      if (in_mem && !mis_mem)      o_wb_data = ld_ext;
      else if (in_tmr && !mis_tmr) o_wb_data = tmr_rdata;
    end
  end

endmodule
